// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_arith_pkg;

    localparam int unsigned DefaultWidth = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

    // Bit counter width; a 1-bit counter is the floor for WIDTH == 2.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/sub_cell.sv
// One-bit subtract cell: full adder on (a, ~b, cin), giving a - b one bit at a time.
module sub_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    logic b_n;

    assign b_n    = ~b_i;
    assign s_o    = a_i ^ b_n ^ cin_i;
    assign cout_o = (a_i & b_n) | (a_i & cin_i) | (b_n & cin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing a - b as a + ~b + 1, LSB first, one bit per clock.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf_o.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH:0]   diff_o,
    output logic             borrow_o,
    output logic             zero_o
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int unsigned   CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] ra_q;
    logic [WIDTH-1:0] rb_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [CntW-1:0]  cnt_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic             zero_q;
    logic [WIDTH:0]   diff_q;
    logic             sum;
    logic             cout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf_q;
`endif

    sub_cell u_cell (
        .a_i    (ra_q[0]),
        .b_i    (rb_q[0]),
        .cin_i  (carry_q),
        .s_o    (sum),
        .cout_o (cout)
    );

    // Sum bits enter from the MSB side so the LSB lands at bit 0 after WIDTH shifts.
    assign res_d = {sum, res_q[WIDTH-1:1]};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            ra_q    <= '0;
            rb_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
            diff_q  <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        ra_q    <= a_i;
                        rb_q    <= b_i;
                        carry_q <= 1'b1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    ra_q    <= ra_q >> 1;
                    rb_q    <= rb_q >> 1;
                    res_q   <= res_d;
                    carry_q <= cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        diff_q  <= {~cout, res_d};
                        zero_q  <= (res_d == '0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        // carry_q here is the carry into the MSB column.
                        ovf_q   <= carry_q ^ cout;
`endif
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign diff_o   = diff_q;
    assign borrow_o = diff_q[WIDTH];
    assign zero_o   = zero_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign ovf_o    = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned/two's-complement subtractor computing a − b, one bit per clock.
- Implemented as a + ~b + 1 through a single full-adder-style cell plus a carry flip-flop.
- Complements the combinational ripple-carry adder datapath.
- Area-cheap ALU subtract path with a start/busy/done handshake.

Parameters:
- WIDTH, 4, operand width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; latched when start is accepted.
- b  input  WIDTH  subtrahend; latched when start is accepted.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH+1  {borrow, a−b mod 2^WIDTH}; held until the next accepted start.
- borrow  output  1  1 when a < b (unsigned); equals diff[WIDTH].
- zero  output  1  1 when diff[WIDTH-1:0] == 0.
- ovf  output  1  signed overflow; present only with the optional feature.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - busy, done, borrow, zero = 0; ovf = 0.
  - diff = 0; internal shift registers, counter and carry flip-flop = 0.
- FSM states:
  - IDLE: if start=1 at edge k, latch a→ra, b→rb, set carry=1, cnt=0, go to SHIFT.
  - SHIFT: each edge processes bit ra[0], ~rb[0], carry:
    - sum bit shifts into the result register from the MSB side;
    - ra and rb shift right;
    - carry takes the cell carry-out;
    - cnt increments.
  - SHIFT exit: on the edge where cnt == WIDTH−1, go to DONE and update outputs:
    - diff = {~carry_out, result};
    - borrow = ~carry_out;
    - zero from the result;
    - ovf = carry-into-MSB XOR carry-out.
  - DONE: done=1 for exactly one cycle; next edge returns to IDLE.
- Latency:
  - start accepted at edge k; the WIDTH bits are processed at edges k+1 … k+WIDTH.
  - done is high during the cycle following edge k+WIDTH.
  - busy is high from after edge k until the edge that returns to IDLE (k+WIDTH+1).
  - A new start is accepted at edge k+WIDTH+2 at the earliest; the next operation takes WIDTH+2 cycles.
- Arithmetic:
  - Operands are treated as unsigned for borrow.
  - diff[WIDTH-1:0] is the two's-complement difference.
  - Example at WIDTH=4: 3−5 gives diff = 1_1110.
- Boundary conditions:
  - start while busy (SHIFT or DONE) is ignored; latched operands are unaffected.
  - Changes to a or b after acceptance do not affect the result.
  - a == b gives diff = 0, zero=1, borrow=0.
  - 0 − (2^WIDTH−1) gives diff = {1, 0…01}.
  - Reset asserted mid-SHIFT immediately (asynchronously) forces IDLE and clears all outputs; no done pulse follows.
  - diff, borrow, zero and ovf change only at the DONE transition or at reset.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - the ovf port exists;
  - the carry into the MSB is captured during the last SHIFT cycle;
  - ovf = 1 when the signed result a−b is not representable in WIDTH bits;
  - ovf updates together with diff.
- Undefined: the ovf port and its capture flip-flop are absent; all other behaviour is identical.

Decomposition:
- Package serial_arith_pkg:
  - state encoding localparams IDLE=2'b00, SHIFT=2'b01, DONE=2'b10;
  - default WIDTH constant;
  - counter width computed as clog2(WIDTH).
- Sub-module sub_cell:
  - 1-bit cell with inputs a, b, cin; outputs s = a^~b^cin and cout;
  - instantiated once inside serial_subtractor.

Test Plan:
- WIDTH=4, reset then start with a=0101, b=0011 → after 4 shift edges done pulses once; diff=0_0010, borrow=0, zero=0.
- a=0011, b=0101 → diff=1_1110, borrow=1, zero=0; done high exactly one cycle, 5 edges after start accepted.
- a=1000, b=1000 → diff=0_0000, zero=1, borrow=0; with OVF_EN, ovf=0.
- With OVF_EN: a=1000, b=0001 → diff=0_0111, ovf=1; then a=0111, b=1111 → diff=1_1000, ovf=1, borrow=1.
- Start with a=0001, b=0000; assert start again and change a/b during SHIFT → ignored, result diff=0_0001; back-to-back starts every 6 cycles yield correct successive results.
- Start a=0000, b=0001; pulse reset at shift cycle 2 → busy=0, done never pulses, diff=0; a following start with a=0000, b=0001 gives diff=1_1111.
